masked_hpc3_mul_stream: RTL and testbench

- Streaming, back-pressurable HPC3 masked multiplier over GF(2^BIT_WIDTH), built from generic_mul and reduce_xor.
- Each transaction carries all operand shares and fresh randomness together.
- Per-stage valid bits, a valid/ready handshake and a configurable number of output pipeline stages.
- Used in AES S-box datapaths where the producer or consumer can stall.

---
 rtl/masked_hpc3_mul_stream.sv | 181 ++++++++++++++++++
 tb/tb_masked_hpc3_mul_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_hpc3_mul_stream.sv
// Streaming HPC3 masked multiplier over GF(2^BIT_WIDTH) with valid/ready pipeline.
// Define MASKED_HPC3_MUL_STREAM_ZEROIZE_EN to clear data registers of stages that empty.
module masked_hpc3_mul_stream #(
    parameter int NUM_SHARES   = 2,
    parameter int BIT_WIDTH    = 2,
    parameter int EXTRA_STAGES = 0,
    localparam int NUM_QUAD    = NUM_SHARES * (NUM_SHARES - 1) / 2,
    localparam int CNT_W       = $clog2(EXTRA_STAGES + 3)
) (
    input  logic                            in_clock,
    input  logic                            in_reset,
    input  logic                            in_valid,
    output logic                            out_ready,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0] in_a,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0] in_b,
    input  logic [NUM_QUAD*BIT_WIDTH-1:0]   in_r,
    input  logic [NUM_QUAD*BIT_WIDTH-1:0]   in_p,
    output logic                            out_valid,
    input  logic                            in_ready,
    output logic [NUM_SHARES*BIT_WIDTH-1:0] out_c,
    output logic [CNT_W-1:0]                out_inflight
);

    localparam int W  = BIT_WIDTH;
    localparam int N  = NUM_SHARES;
    localparam int NS = 2 + EXTRA_STAGES;
    localparam int NW = N * W;
    localparam int PW = N * (N - 1) * W;

    function automatic logic [31:0] field_poly(input int w);
        case (w)
            1:       return 32'h0;
            5:       return 32'h5;
            8:       return 32'h1B;
            default: return 32'h3;
        endcase
    endfunction

    localparam logic [31:0]  POLY32 = field_poly(W);
    localparam logic [W-1:0] POLY   = POLY32[W-1:0];

    // R and P are shared by the pair (i,j) and (j,i), so the P terms cancel.
    function automatic int qindex(input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * N - lo * (lo + 1) / 2 + hi - lo - 1;
    endfunction

    function automatic logic [W-1:0] generic_mul(input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = W - 1; k >= 0; k--) begin
            acc = (acc << 1) ^ ({W{acc[W-1]}} & POLY);
            if (y[k]) acc = acc ^ x;
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] reduce_xor(input logic [PW-1:0] v,
                                                input int i);
        logic [W-1:0] s;
        s = '0;
        for (int jj = 0; jj < N - 1; jj++) s = s ^ v[(i*(N-1)+jj)*W +: W];
        return s;
    endfunction

    logic [NS-1:0] valid_q, valid_d, adv;
    logic [NW-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0] v_q, v_d, w_q, w_d;
    logic [NW-1:0] c_q [1:NS-1];
    logic [NW-1:0] c_d [1:NS-1];
    logic [PW-1:0] v_new, w_new;
    logic [NW-1:0] c_new;
    logic [W-1:0]  r_ij;
    logic          accept;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        v_new = '0;
        w_new = '0;
        r_ij  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i) begin
                    r_ij = in_r[qindex(i, j)*W +: W];
                    v_new[(i*(N-1)+((j < i) ? j : j - 1))*W +: W] =
                        in_b[j*W +: W] ^ r_ij;
                    w_new[(i*(N-1)+((j < i) ? j : j - 1))*W +: W] =
                        in_p[qindex(i, j)*W +: W] ^ generic_mul(in_a[i*W +: W], r_ij);
                end
            end
        end
    end

    // Compression sees only S1 registers, never the input ports.
    always_comb begin
        c_new = '0;
        for (int i = 0; i < N; i++) begin
            c_new[i*W +: W] =
                generic_mul(a_q[i*W +: W], b_q[i*W +: W] ^ reduce_xor(v_q, i))
                ^ reduce_xor(w_q, i);
        end
    end

    always_comb begin
        adv = '0;
        adv[NS-1] = valid_q[NS-1] & in_ready;
        for (int k = NS - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
        end
        out_ready = ~valid_q[0] | adv[0];
        accept    = in_valid & out_ready;
    end

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        v_d     = v_q;
        w_d     = w_q;
        c_d     = c_q;
        valid_d[0] = accept | (valid_q[0] & ~adv[0]);
        for (int k = 1; k < NS; k++) begin
            valid_d[k] = adv[k-1] | (valid_q[k] & ~adv[k]);
        end
        if (accept) begin
            a_d = in_a;
            b_d = in_b;
            v_d = v_new;
            w_d = w_new;
        end
`ifdef MASKED_HPC3_MUL_STREAM_ZEROIZE_EN
        else if (adv[0]) begin
            a_d = '0;
            b_d = '0;
            v_d = '0;
            w_d = '0;
        end
`endif
        for (int k = 1; k < NS; k++) begin
            if (adv[k-1]) begin
                c_d[k] = (k == 1) ? c_new : c_q[(k > 1) ? k - 1 : 1];
            end
`ifdef MASKED_HPC3_MUL_STREAM_ZEROIZE_EN
            else if (adv[k]) begin
                c_d[k] = '0;
            end
`endif
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            v_q     <= '0;
            w_q     <= '0;
            for (int k = 1; k < NS; k++) c_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v_q     <= v_d;
            w_q     <= w_d;
            for (int k = 1; k < NS; k++) c_q[k] <= c_d[k];
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < NS; k++) cnt = cnt + {{(CNT_W-1){1'b0}}, valid_q[k]};
    end

    assign out_valid    = valid_q[NS-1];
    assign out_c        = c_q[NS-1];
    assign out_inflight = cnt;

endmodule

// File: tb/tb_masked_hpc3_mul_stream.sv
// Scoreboard bench for masked_hpc3_mul_stream (3 shares, GF(4), two extra stages).
// Unmasked results are checked against a hand-written GF(4) product table.
module tb_masked_hpc3_mul_stream;

    localparam int N  = 3;
    localparam int W  = 2;
    localparam int E  = 2;
    localparam int Q  = N * (N - 1) / 2;
    localparam int L  = 2 + E;
    localparam int CW = $clog2(E + 3);

    logic            in_clock = 1'b0;
    logic            in_reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready = 1'b1;
    logic [N*W-1:0]  in_a = '0;
    logic [N*W-1:0]  in_b = '0;
    logic [Q*W-1:0]  in_r = '0;
    logic [Q*W-1:0]  in_p = '0;
    logic            out_ready;
    logic            out_valid;
    logic [N*W-1:0]  out_c;
    logic [CW-1:0]   out_inflight;

    masked_hpc3_mul_stream #(
        .NUM_SHARES(N), .BIT_WIDTH(W), .EXTRA_STAGES(E)
    ) dut (
        .in_clock(in_clock), .in_reset(in_reset), .in_valid(in_valid),
        .out_ready(out_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
        .in_p(in_p), .out_valid(out_valid), .in_ready(in_ready),
        .out_c(out_c), .out_inflight(out_inflight)
    );

    always #5 in_clock = ~in_clock;

    // GF(4) with x^2 = x + 1, computed by hand.
    logic [1:0] gf4 [4][4] = '{
        '{2'd0, 2'd0, 2'd0, 2'd0},
        '{2'd0, 2'd1, 2'd2, 2'd3},
        '{2'd0, 2'd2, 2'd3, 2'd1},
        '{2'd0, 2'd3, 2'd1, 2'd2}
    };
    int vec_a [16] = '{1, 2, 2, 3, 3, 0, 2, 3, 1, 2, 3, 1, 0, 3, 2, 1};
    int vec_b [16] = '{1, 2, 3, 3, 2, 3, 1, 1, 2, 0, 0, 3, 0, 2, 2, 1};

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt = 0;
    logic [W-1:0]   exp_q [$];
    logic [W-1:0]   share0_log [$];
    logic [N*W-1:0] last_c = '0;
    bit             log_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] unmask(input logic [N*W-1:0] s);
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i < N; i++) x = x ^ s[i*W +: W];
        return x;
    endfunction

    function automatic logic [N*W-1:0] mask(input logic [W-1:0] v);
        logic [31:0]    t;
        logic [N*W-1:0] s;
        t = $urandom;
        s = t[N*W-1:0];
        s[(N-1)*W +: W] = v ^ unmask({{W{1'b0}}, s[(N-1)*W-1:0]});
        return s;
    endfunction

    // Monitor: one result leaves on each negedge sample with valid && ready.
    always @(negedge in_clock) begin
        if (in_reset && out_valid && in_ready) begin
            last_c = out_c;
            if (log_en) share0_log.push_back(out_c[W-1:0]);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h expected none", out_c);
            end else begin
                chk("result", 32'(unmask(out_c)), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic [Q*W-1:0] r, input logic [Q*W-1:0] p,
                         input logic [W-1:0] exp_c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_r = r;
        in_p = p;
        for (int t = 0; t < 200; t++) begin
            @(negedge in_clock);
            if (out_ready) begin
                exp_q.push_back(exp_c);
                @(posedge in_clock);
                #1;
                in_valid = 1'b0;
                return;
            end
            stall_cnt++;
        end
        chk("accept_timeout", 32'(out_ready), 1);
        in_valid = 1'b0;
    endtask

    task automatic drive_ab(input int a, input int b);
        logic [31:0] t1, t2;
        t1 = $urandom;
        t2 = $urandom;
        drive(mask(W'(a)), mask(W'(b)), t1[Q*W-1:0], t2[Q*W-1:0], gf4[a][b]);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge in_clock);
        #1;
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int lat, run, distinct;
        logic [N*W-1:0] hold;
        int drain_exp [4] = '{3, 2, 1, 0};

        repeat (2) @(posedge in_clock);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_inflight", 32'(out_inflight), 0);
        chk("rst_c", 32'(out_c), 0);
        in_reset = 1'b1;
        @(posedge in_clock);
        #1;
        chk("rst_ready", 32'(out_ready), 1);

        // single transfer: latency and occupancy trace
        drive_ab(2, 3);
        lat = 0;
        for (int s = 0; s <= L; s++) begin
            chk($sformatf("single_infl%0d", s), 32'(out_inflight), (s < L) ? 1 : 0);
            if (out_valid && lat == 0) lat = s + 1;
            if (s < L) begin
                @(posedge in_clock);
                #1;
            end
        end
        chk("single_latency", lat, L);

        // back-to-back stream
        stall_cnt = 0;
        run = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) drive_ab(vec_a[i], vec_b[i]);
            end
            begin
                for (int t = 0; t < 100 && !out_valid; t++) @(negedge in_clock);
                for (int k = 0; k < 16; k++) begin
                    if (out_valid) run++;
                    @(negedge in_clock);
                end
            end
        join
        chk("stream_run", run, 16);
        chk("stream_stalls", stall_cnt, 0);
        wait_drain();

        // backpressure: fill, hold, accept+emit at full, drain
        @(posedge in_clock);
        #1;
        in_ready = 1'b0;
        for (int i = 0; i < L; i++) drive_ab(vec_a[i+3], vec_b[i+3]);
        chk("full_infl", 32'(out_inflight), L);
        chk("full_ready", 32'(out_ready), 0);
        chk("full_valid", 32'(out_valid), 1);
        hold = out_c;
        for (int s = 0; s < 5; s++) begin
            @(posedge in_clock);
            #1;
            chk($sformatf("stall_hold%0d", s), 32'(out_c), 32'(hold));
        end
        in_ready = 1'b1;
        drive_ab(1, 3);
        chk("full_swap_infl", 32'(out_inflight), L);
        for (int s = 0; s < 4; s++) begin
            @(posedge in_clock);
            #1;
            chk($sformatf("drain_infl%0d", s), 32'(out_inflight), drain_exp[s]);
        end
        wait_drain();

        // randomness independence: fixed shares of 3 and 3, varying P
        log_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] t;
            logic [Q*W-1:0] pv;
            t = $urandom;
            pv = '0;
            pv[1:0] = 2'(k);
            drive({2'b01, 2'b11, 2'b01}, {2'b10, 2'b00, 2'b01}, t[Q*W-1:0], pv, gf4[3][3]);
        end
        wait_drain();
        repeat (2) @(posedge in_clock);
        log_en = 1'b0;
        distinct = 0;
        for (int v = 0; v < 4; v++) begin
            bit seen;
            seen = 1'b0;
            foreach (share0_log[i]) if (share0_log[i] == W'(v)) seen = 1'b1;
            if (seen) distinct++;
        end
        chk("rand_share_variety", distinct, 4);
        chk("rand_count", share0_log.size(), 10);

        // reset with two transactions in flight
        #1;
        in_ready = 1'b0;
        drive_ab(2, 2);
        drive_ab(3, 1);
        chk("pre_rst_infl", 32'(out_inflight), 2);
        in_reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_c", 32'(out_c), 0);
        chk("mid_rst_infl", 32'(out_inflight), 0);
        exp_q.delete();
        @(negedge in_clock);
        in_reset = 1'b1;
        @(posedge in_clock);
        #1;
        chk("post_rst_ready", 32'(out_ready), 1);
        in_ready = 1'b1;
        drive_ab(3, 2);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge in_clock);
            #1;
            lat++;
        end
        chk("post_rst_latency", lat, L);
        wait_drain();

        // idle output contents
        repeat (2) @(posedge in_clock);
        #1;
        chk("idle_valid", 32'(out_valid), 0);
`ifdef MASKED_HPC3_MUL_STREAM_ZEROIZE_EN
        chk("idle_c", 32'(out_c), 0);
`else
        chk("idle_c", 32'(out_c), 32'(last_c));
`endif
        chk("idle_infl", 32'(out_inflight), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
